// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP48A1 MAC sequencer.
package dsp_pkg;

  localparam int unsigned AB_W        = 18;
  localparam int unsigned OPMODE_W    = 8;
  localparam int unsigned P_W         = 48;
  localparam int unsigned DSP_LATENCY = 3;

  // X=M, Z=0: start a new accumulation
  localparam logic [OPMODE_W-1:0] OPMODE_MAC_FIRST = 8'h01;
  // X=M, Z=P: accumulate onto P
  localparam logic [OPMODE_W-1:0] OPMODE_MAC_ACC   = 8'h09;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } token_t;

  typedef enum logic {
    ST_DSP_RST = 1'b0,
    ST_RUN     = 1'b1
  } seq_state_e;

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Operand stream, DSP slice connection and result stream of the MAC sequencer.
interface dsp_mac_sequencer_if #(
  parameter int unsigned OUT_W = 48,
  parameter int unsigned CNT_W = 16
);
  import dsp_pkg::*;

  logic                s_valid;
  logic                s_ready;
  logic [AB_W-1:0]     s_a;
  logic [AB_W-1:0]     s_b;
  logic                s_last;

  logic [AB_W-1:0]     dsp_a;
  logic [AB_W-1:0]     dsp_b;
  logic [OPMODE_W-1:0] dsp_opmode;
  logic                dsp_ce;
  logic                dsp_rst;
  logic [P_W-1:0]      dsp_p;

  logic                m_valid;
  logic                m_ready;
  logic [OUT_W-1:0]    m_data;
  logic [CNT_W-1:0]    m_count;

  // Environment side: produces operands, owns the DSP slice, consumes results
  modport master (
    output s_valid, s_a, s_b, s_last, dsp_p, m_ready,
    input  s_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce, dsp_rst,
           m_valid, m_data, m_count
  );

  // Sequencer side
  modport slave (
    input  s_valid, s_a, s_b, s_last, dsp_p, m_ready,
    output s_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce, dsp_rst,
           m_valid, m_data, m_count
  );

endinterface

// File: rtl/dsp_mac_sequencer_token_pipe.sv
// Enabled token shift register that mirrors the DSP slice pipeline depth.
module dsp_token_pipe
  import dsp_pkg::*;
#(
  parameter int unsigned DEPTH = DSP_LATENCY,
  parameter int unsigned TAP   = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  input  token_t tok_i,
  output token_t tap_o,
  output token_t exit_o
);

  // stg_q[k] holds the token issued k enabled cycles ago
  token_t stg_q [1:DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= int'(DEPTH); i++) stg_q[i] <= '0;
    end else if (en_i) begin
      stg_q[1] <= tok_i;
      for (int i = 2; i <= int'(DEPTH); i++) stg_q[i] <= stg_q[i-1];
    end
  end

  generate
    if (TAP == 0) begin : g_tap_in
      assign tap_o = tok_i;
    end else begin : g_tap_stg
      assign tap_o = stg_q[TAP];
    end
  endgenerate

  assign exit_o = stg_q[DEPTH];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Feeds a DSP48A1 slice with operand pairs and collects one P per dot product.
// Define DSP_MAC_SAT_EN to saturate m_data to OUT_W instead of truncating.
module dsp_mac_sequencer
  import dsp_pkg::*;
#(
  parameter int unsigned LATENCY    = DSP_LATENCY,
  parameter int unsigned OPMODE_DLY = 1,
  parameter int unsigned OUT_W      = 48,
  parameter int unsigned CNT_W      = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  dsp_mac_sequencer_if.slave  bus
);

  seq_state_e       state_q, state_d;
  logic             first_pend_q, first_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m_valid_q, m_valid_d;
  logic [OUT_W-1:0] m_data_q, m_data_d;
  logic [CNT_W-1:0] m_count_q, m_count_d;

  logic             stall_c;
  logic             ce_c;
  logic             hs_c;
  logic [OUT_W-1:0] p_conv_c;
  token_t           tok_in_c;
  token_t           tok_tap_c;
  token_t           tok_exit_c;

  // A finished dot product that cannot be stored freezes the whole slice
  assign stall_c = tok_exit_c.valid && tok_exit_c.last && m_valid_q && !bus.m_ready;
  assign ce_c    = (state_q == ST_RUN) && !stall_c;
  assign hs_c    = ce_c && bus.s_valid;

  always_comb begin
    tok_in_c = '0;
    if (hs_c) begin
      tok_in_c.valid = 1'b1;
      tok_in_c.first = first_pend_q;
      tok_in_c.last  = bus.s_last;
    end
  end

  dsp_token_pipe #(
    .DEPTH (LATENCY),
    .TAP   (OPMODE_DLY)
  ) u_token_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (ce_c),
    .tok_i  (tok_in_c),
    .tap_o  (tok_tap_c),
    .exit_o (tok_exit_c)
  );

`ifdef DSP_MAC_SAT_EN
  logic [P_W-OUT_W:0] p_hi_c;
  assign p_hi_c = bus.dsp_p[P_W-1:OUT_W-1];

  // Saturate when the bits above the OUT_W sign bit are not a pure sign extension
  always_comb begin
    p_conv_c = bus.dsp_p[OUT_W-1:0];
    if (!((p_hi_c == '0) || (p_hi_c == '1))) begin
      p_conv_c = bus.dsp_p[P_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                  : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  assign p_conv_c = bus.dsp_p[OUT_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_DSP_RST;
      first_pend_q <= 1'b1;
      cnt_q        <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_count_q    <= '0;
    end else begin
      state_q      <= state_d;
      first_pend_q <= first_pend_d;
      cnt_q        <= cnt_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_count_q    <= m_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    first_pend_d = first_pend_q;
    cnt_d        = cnt_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_count_d    = m_count_q;

    // One clock with the DSP sync reset asserted, then run forever
    case (state_q)
      ST_DSP_RST: state_d = ST_RUN;
      ST_RUN:     state_d = ST_RUN;
      default:    state_d = ST_DSP_RST;
    endcase

    if (hs_c) first_pend_d = bus.s_last;

    if (m_valid_q && bus.m_ready) m_valid_d = 1'b0;

    if (ce_c && tok_exit_c.valid) begin
      cnt_d = tok_exit_c.first ? CNT_W'(1) : cnt_q + CNT_W'(1);
      if (tok_exit_c.last) begin
        m_valid_d = 1'b1;
        m_data_d  = p_conv_c;
        m_count_d = cnt_d;
      end
    end
  end

  assign bus.s_ready    = ce_c;
  assign bus.dsp_ce     = ce_c;
  assign bus.dsp_rst    = (state_q == ST_DSP_RST);
  assign bus.dsp_a      = hs_c ? bus.s_a : '0;
  assign bus.dsp_b      = hs_c ? bus.s_b : '0;
  assign bus.dsp_opmode = (tok_tap_c.valid && tok_tap_c.first) ? OPMODE_MAC_FIRST
                                                               : OPMODE_MAC_ACC;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_count    = m_count_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: DSP48A1 slice model, dot-product scoreboard, directed and random stimulus.
module tb_dsp_mac_sequencer;

  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;
  int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

  typedef struct {
    longint data;
    int     cnt;
  } res_t;

  res_t   exp_q[$];
  longint acc = 0;
  int     nterm = 0;

  dsp_mac_sequencer_if #(.OUT_W(48), .CNT_W(16)) bus ();
  dsp_mac_sequencer_if #(.OUT_W(16), .CNT_W(16)) bus16 ();

  dsp_mac_sequencer #(.LATENCY(LAT), .OPMODE_DLY(1), .OUT_W(48), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Narrow-output twin sharing every input with the main instance
  dsp_mac_sequencer #(.LATENCY(LAT), .OPMODE_DLY(1), .OUT_W(16), .CNT_W(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  assign bus16.s_valid = bus.s_valid;
  assign bus16.s_a     = bus.s_a;
  assign bus16.s_b     = bus.s_b;
  assign bus16.s_last  = bus.s_last;
  assign bus16.m_ready = bus.m_ready;
  assign bus16.dsp_p   = bus.dsp_p;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [15:0] conv16(input longint v);
`ifdef DSP_MAC_SAT_EN
    if (v > 64'sd32767)  return 16'h7fff;
    if (v < -64'sd32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  // DSP48A1 with A1REG/B1REG/MREG/PREG/OPMODEREG, shared CE and sync reset
  logic signed [17:0] a1_q, b1_q;
  logic signed [35:0] m_q;
  logic        [7:0]  op_q;
  logic signed [47:0] p_q;

  always @(posedge clk) begin
    if (bus.dsp_rst) begin
      a1_q <= '0; b1_q <= '0; m_q <= '0; op_q <= '0; p_q <= '0;
    end else if (bus.dsp_ce) begin
      a1_q <= bus.dsp_a;
      b1_q <= bus.dsp_b;
      m_q  <= a1_q * b1_q;
      op_q <= bus.dsp_opmode;
      p_q  <= ((op_q[3:2] == 2'b10) ? p_q : 48'sd0) +
              ((op_q[1:0] == 2'b01) ? {{12{m_q[35]}}, m_q} : 48'sd0);
    end
  end
  assign bus.dsp_p = p_q;

  // Scoreboard: dot products of accepted pairs, checked on every cycle a result is shown
  longint     mon_d;
  logic [47:0] mon_e48;
  logic [15:0] mon_c16;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc   = 0;
      nterm = 0;
    end else begin
      if (bus.m_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(bus.m_valid), 64'd0);
        end else begin
          mon_d   = exp_q[0].data;
          mon_e48 = mon_d[47:0];
          mon_c16 = 16'(exp_q[0].cnt);
          chk("m_data",    64'(bus.m_data),    64'(mon_e48));
          chk("m_count",   64'(bus.m_count),   64'(mon_c16));
          chk("m_data16",  64'(bus16.m_data),  64'(conv16(mon_d)));
          chk("m_valid16", 64'(bus16.m_valid), 64'd1);
          if (bus.m_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.s_valid && bus.s_ready) begin
        acc += longint'($signed(bus.s_a)) * longint'($signed(bus.s_b));
        nterm++;
        if (bus.s_last) begin
          exp_q.push_back('{acc, nterm});
          acc   = 0;
          nterm = 0;
        end
      end
    end
  end

  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.m_ready = 1'b0;
        1:       bus.m_ready = 1'b1;
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Present one pair from just after a rising edge until it is accepted
  task automatic send(input logic signed [17:0] a, input logic signed [17:0] b, input logic last);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_a     = a;
    bus.s_b     = b;
    bus.s_last  = last;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.s_ready && n < 500);
    if (n >= 500) chk("s_ready_timeout", 64'(bus.s_ready), 64'd1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_a     = '0;
    bus.s_b     = '0;
    bus.s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Rising edges after the issue edge until m_valid appears
  task automatic wait_result(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.m_valid && n < 200);
    chk("result_timeout", 64'(bus.m_valid), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [47:0] neg86;
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_a     = '0;
    bus.s_b     = '0;
    bus.s_last  = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready",    64'(bus.s_ready),    64'd0);
    chk("rst_dsp_ce",     64'(bus.dsp_ce),     64'd0);
    chk("rst_dsp_rst",    64'(bus.dsp_rst),    64'd1);
    chk("rst_dsp_opmode", 64'(bus.dsp_opmode), 64'h09);
    chk("rst_dsp_a",      64'(bus.dsp_a),      64'd0);
    chk("rst_m_valid",    64'(bus.m_valid),    64'd0);
    chk("rst_m_data",     64'(bus.m_data),     64'd0);
    chk("rst_m_count",    64'(bus.m_count),    64'd0);

    // Release: DSP reset spans the first edge, then the slice runs
    rst_n = 1'b1;
    #1;
    chk("rel_dsp_rst_hold", 64'(bus.dsp_rst), 64'd1);
    chk("rel_s_ready_low",  64'(bus.s_ready), 64'd0);
    @(negedge clk);
    chk("rel_dsp_rst_drop", 64'(bus.dsp_rst), 64'd0);
    chk("rel_s_ready_high", 64'(bus.s_ready), 64'd1);
    chk("rel_dsp_ce_high",  64'(bus.dsp_ce),  64'd1);
    @(posedge clk); #1;

    // 3*4 + 5*-6 + 7*8 = 38, result LATENCY edges after the last issue
    send(18'sd3, 18'sd4, 1'b0);
    send(18'sd5, -18'sd6, 1'b0);
    send(18'sd7, 18'sd8, 1'b1);
    wait_result(n);
    chk("dp3_latency", 64'(n), 64'(LAT));
    chk("dp3_data",    64'(bus.m_data),  64'd38);
    chk("dp3_count",   64'(bus.m_count), 64'd3);

    // Most negative operands squared: 2^34
    send(-18'sd131072, -18'sd131072, 1'b1);
    wait_result(n);
    chk("single_data",  64'(bus.m_data),  64'd17179869184);
    chk("single_count", 64'(bus.m_count), 64'd1);
    idle(2);

    // Two results with no consumer: first held, slice stalls on the second
    @(negedge clk); ready_mode = 0;
    @(posedge clk); #1;
    send(18'sd1, 18'sd2, 1'b0);
    send(18'sd3, 18'sd4, 1'b1);
    send(-18'sd5, 18'sd6, 1'b0);
    send(18'sd7, -18'sd8, 1'b1);
    idle(8);
    chk("stall_dsp_ce",  64'(bus.dsp_ce),  64'd0);
    chk("stall_s_ready", 64'(bus.s_ready), 64'd0);
    chk("stall_m_valid", 64'(bus.m_valid), 64'd1);
    chk("stall_m_data",  64'(bus.m_data),  64'd14);
    @(negedge clk); ready_mode = 1;
    @(negedge clk); ready_mode = 0;
    @(posedge clk); #1;
    neg86 = -48'sd86;
    chk("b2b_m_valid", 64'(bus.m_valid), 64'd1);
    chk("b2b_m_data",  64'(bus.m_data),  64'(neg86));
    chk("b2b_m_count", 64'(bus.m_count), 64'd2);
    chk("b2b_dsp_ce",  64'(bus.dsp_ce),  64'd1);
    @(negedge clk); ready_mode = 1;
    drain();

    // Reset in the middle of a dot product discards the partial sum
    send(18'sd1000, 18'sd1000, 1'b0);
    send(18'sd2, 18'sd2, 1'b0);
    rst_n = 1'b0;
    idle(2);
    chk("midrst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("midrst_dsp_rst", 64'(bus.dsp_rst), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(18'sd9, 18'sd9, 1'b1);
    wait_result(n);
    chk("midrst_data",  64'(bus.m_data),  64'd81);
    chk("midrst_count", 64'(bus.m_count), 64'd1);
    idle(2);

    // Narrow output: 2 * 300*300 = 180000 does not fit 16 bits
    send(18'sd300, 18'sd300, 1'b0);
    send(18'sd300, 18'sd300, 1'b1);
    wait_result(n);
    chk("wide_data",   64'(bus.m_data),  64'd180000);
    chk("wide_count",  64'(bus.m_count), 64'd2);
`ifdef DSP_MAC_SAT_EN
    chk("narrow_data", 64'(bus16.m_data), 64'd32767);
`else
    chk("narrow_data", 64'(bus16.m_data), 64'd48928);
`endif
    idle(2);

    // Random 8-term dot products with bubbles and random back-pressure
    @(negedge clk); ready_mode = 2;
    @(posedge clk); #1;
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 8; k++) begin
        send(18'($urandom), 18'($urandom), k == 7);
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end
    end
    @(negedge clk); ready_mode = 1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
